// File: rtl/pls_arb_pkg.sv
// pls_arb_pkg: shared types, defaults and round-robin pick for pulse_arbiter.
package pls_arb_pkg;
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;
    localparam int N_DEF = 4;
    localparam int PEND_W_DEF = 2;
    // First nonzero channel after last_id, wrapping modulo n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] pending_nz, input logic [2:0] last_id, input int n);
        logic [2:0] r;
        r = last_id;
        for (int k = n; k >= 1; k--) begin
            int idx;
            idx = (int'(last_id) + k) % n;
            if (pending_nz[idx[2:0]]) r = idx[2:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/pls_chan.sv
// pls_chan: one channel's optional synchronizer, edge detector, saturating pending counter and overflow flag.
// PLS_ARB_SYNC_EN adds a 2-flop input synchronizer ahead of the edge detector.
module pls_chan #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn,
    input  logic              clr_ovf,
    input  logic              dec,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    logic btn_s, btn_q, ev, full, drop;
`ifdef PLS_ARB_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '0;
        else sync <= {sync[0], btn};
    assign btn_s = sync[1];
`else
    assign btn_s = btn;
`endif
    assign ev = btn_s & ~btn_q;
    assign full = &pending;
    assign drop = ev & ~dec & full;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            btn_q    <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            btn_q <= btn_s;
            if (ev && !dec && !full) pending <= pending + PEND_W'(1);
            else if (dec && !ev) pending <= pending - PEND_W'(1);
            overflow <= drop | (overflow & ~clr_ovf);
        end
endmodule

// File: rtl/pulse_arbiter.sv
// pulse_arbiter: round-robin valid/ready server of per-channel button events to one consumer.
// Define PLS_ARB_SYNC_EN to synchronize asynchronous btn inputs (adds 2 cycles latency).
module pulse_arbiter
    import pls_arb_pkg::*;
#(
    parameter  int N      = N_DEF,
    parameter  int PEND_W = PEND_W_DEF,
    localparam int ID_W   = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    btn,
    input  logic            clr_ovf,
    input  logic            grant_ready,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic [N-1:0]    overflow
);
    logic [PEND_W-1:0] pending [N];
    logic [N-1:0]      nz, dec;
    logic [ID_W-1:0]   last_id, pick;
    state_t            state;
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_chan
            assign dec[i] = grant_valid & grant_ready & (grant_id == ID_W'(i));
            assign nz[i]  = |pending[i];
            pls_chan #(.PEND_W(PEND_W)) u_chan (
                .clk      (clk),
                .reset    (reset),
                .btn      (btn[i]),
                .clr_ovf  (clr_ovf),
                .dec      (dec[i]),
                .pending  (pending[i]),
                .overflow (overflow[i])
            );
        end
    endgenerate
    assign pick        = ID_W'(rr_pick(8'(nz), 3'(last_id), N));
    assign grant_valid = state == OFFER;
    assign busy        = (|nz) | grant_valid;
    // Arbitration sees only registered pending counts; grant_id is frozen while offering.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= ID_W'(N - 1);
        end else if (state == IDLE) begin
            if (|nz) begin
                grant_id <= pick;
                state    <= OFFER;
            end
        end else if (grant_ready) begin
            last_id <= grant_id;
            state   <= IDLE;
        end
endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter: directed and random checks of pulse_arbiter against a cycle-level behavioural model.
module tb_pulse_arbiter;
    localparam int N = 4, PEND_W = 2, ID_W = 2, MAX = 3;
`ifdef PLS_ARB_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    logic clk = 0, reset = 1, clr_ovf = 0, grant_ready = 0;
    logic grant_valid, busy;
    logic [N-1:0] btn = '0, overflow;
    logic [ID_W-1:0] grant_id;
    int checks = 0, errors = 0;
    int grants[$];

    pulse_arbiter #(.N(N), .PEND_W(PEND_W)) dut (
        .clk(clk), .reset(reset), .btn(btn), .clr_ovf(clr_ovf), .grant_ready(grant_ready),
        .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int pend[N];
    logic [N-1:0] movf, prevb, s1, s2;
    bit offering;
    int gid, last;
    logic pgv = 0;
    logic [ID_W-1:0] pgid = '0;

    always @(posedge clk) begin : model
        logic [N-1:0] b, sb;
        logic rdy, clr, rst;
        bit hs, any;
        int og;
        b = btn; rdy = grant_ready; clr = clr_ovf; rst = reset;
        if (!rst && pgv && rdy) grants.push_back(int'(pgid));
        if (rst) begin
            foreach (pend[i]) pend[i] = 0;
            movf = '0; prevb = '0; s1 = '0; s2 = '0;
            offering = 0; gid = 0; last = N - 1;
        end else begin
`ifdef PLS_ARB_SYNC_EN
            sb = s2; s2 = s1; s1 = b;
`else
            sb = b;
`endif
            hs = offering && rdy;
            og = gid;
            if (!offering) begin
                for (int k = 1; k <= N; k++)
                    if (!offering && pend[(last + k) % N] > 0) begin
                        offering = 1;
                        gid = (last + k) % N;
                    end
            end else if (rdy) begin
                offering = 0;
                last = gid;
            end
            for (int i = 0; i < N; i++) begin
                bit ev, d;
                ev = sb[i] && !prevb[i];
                d = hs && og == i;
                if (clr) movf[i] = 1'b0;
                if (ev && !d) begin
                    if (pend[i] == MAX) movf[i] = 1'b1;
                    else pend[i]++;
                end else if (d && !ev) pend[i]--;
            end
            prevb = sb;
        end
        #1;
        any = 0;
        foreach (pend[i]) if (pend[i] > 0) any = 1;
        chk("grant_valid", int'(grant_valid), int'(offering));
        if (offering) chk("grant_id", int'(grant_id), gid);
        chk("busy", int'(busy), int'(any || offering));
        chk("overflow", int'(overflow), int'(movf));
        pgv = grant_valid;
        pgid = grant_id;
    end

    task automatic wait_gv(string name, int exp_lat);
        int n = 0;
        while (!grant_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, exp_lat);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 0;
        @(negedge clk);
        // single press
        grants.delete();
        btn[2] = 1; grant_ready = 1;
        wait_gv("single_lat", LAT);
        chk("single_id", int'(grant_id), 2);
        @(negedge clk);
        chk("single_width", int'(grant_valid), 0);
        repeat (8) @(negedge clk);
        btn = '0;
        repeat (3) @(negedge clk);
        chk("single_count", grants.size(), 1);
        if (grants.size() > 0) chk("single_gid", grants[0], 2);
        chk("single_busy", int'(busy), 0);
        // round robin from last_id = N-1
        do_reset();
        grants.delete();
        btn = 4'b1011; grant_ready = 1;
        @(negedge clk);
        btn = '0;
        repeat (10) @(negedge clk);
        chk("rr_count", grants.size(), 3);
        if (grants.size() == 3) begin
            chk("rr_0", grants[0], 0);
            chk("rr_1", grants[1], 1);
            chk("rr_2", grants[2], 3);
        end
        // backpressure
        grants.delete();
        grant_ready = 0; btn[1] = 1;
        @(negedge clk);
        btn = '0;
        wait_gv("bp_lat", LAT - 1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", int'(grant_valid), 1);
            chk("bp_id", int'(grant_id), 1);
            @(negedge clk);
        end
        chk("bp_none", grants.size(), 0);
        grant_ready = 1;
        @(negedge clk);
        grant_ready = 0;
        @(negedge clk);
        chk("bp_one", grants.size(), 1);
        chk("bp_idle", int'(grant_valid), 0);
        // saturation and overflow clear
        grants.delete();
        for (int p = 0; p < 4; p++) begin
            btn[0] = 1; @(negedge clk);
            btn[0] = 0; @(negedge clk);
        end
        repeat (LAT) @(negedge clk);
        chk("sat_ovf", int'(overflow[0]), 1);
        grant_ready = 1;
        repeat (12) @(negedge clk);
        chk("sat_grants", grants.size(), 3);
        foreach (grants[g]) chk("sat_gid", grants[g], 0);
        clr_ovf = 1;
        @(negedge clk);
        clr_ovf = 0;
        chk("sat_clr", int'(overflow[0]), 0);
        // new edge in the same cycle as the handshake on channel 1
        grants.delete();
        grant_ready = 0; btn[1] = 1;
        @(negedge clk);
        btn[1] = 0;
        wait_gv("sim_lat", LAT - 1);
        btn[1] = 1; grant_ready = 1;
        @(negedge clk);
        btn[1] = 0;
        repeat (10) @(negedge clk);
        chk("sim_count", grants.size(), 2);
        foreach (grants[g]) chk("sim_gid", grants[g], 1);
        // async reset while offering
        grant_ready = 0; btn[3] = 1;
        @(negedge clk);
        btn = '0;
        wait_gv("ar_lat", LAT - 1);
        #2 reset = 1;
        #1;
        chk("ar_valid", int'(grant_valid), 0);
        chk("ar_busy", int'(busy), 0);
        @(negedge clk);
        reset = 0;
        grants.delete();
        grant_ready = 1;
        repeat (6) @(negedge clk);
        chk("ar_none", grants.size(), 0);
        // random traffic
        for (int r = 0; r < 400; r++) begin
            @(negedge clk);
            btn = N'($urandom);
            grant_ready = $urandom_range(0, 3) != 0;
            clr_ovf = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 63) == 0;
        end
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
